// File: rtl/split_router.sv
// split_router: buffered multicast fork; flits from one static source port are replicated to every port in a static mask.
// Define SPLIT_ROUTER_PERF_EN to build the forwarded-flit and head-stall counters.
`ifndef DW
`define DW 34
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef SPLIT_ROUTER_BUFFER_DEPTH_LOG
`define SPLIT_ROUTER_BUFFER_DEPTH_LOG 2
`endif

module split_router #(
  parameter logic [4:0]  input_sel   = 5'b10000,
  parameter logic [4:0]  output_mask = 5'b01000,
  parameter int unsigned depth_log   = `SPLIT_ROUTER_BUFFER_DEPTH_LOG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [`DW-1:0]  data_i  [5],
  input  logic            valid_i [5],
  output logic            ready_o [5],
  output logic [`DW-1:0]  data_o  [5],
  output logic            valid_o [5],
  input  logic            ready_i [5],
  output logic [31:0]     fwd_cnt_o,
  output logic [31:0]     stall_cnt_o
);

  localparam int unsigned DEPTH = 1 << depth_log;

  logic [`DW-1:0]     mem_q [DEPTH];
  logic [depth_log:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]         done_q, done_d;
  logic [4:0]         acc;
  logic [`DW-1:0]     in_data;
  logic [`DW-1:0]     head;
  logic               in_valid;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[depth_log-1:0] == rd_ptr_q[depth_log-1:0]) &&
                 (wr_ptr_q[depth_log] != rd_ptr_q[depth_log]);
  assign head  = mem_q[rd_ptr_q[depth_log-1:0]];

  always_comb begin
    in_data  = '0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (input_sel[i]) begin
        in_data  = data_i[i];
        in_valid = valid_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      ready_o[i] = input_sel[i] & ~full & ~rst;
      valid_o[i] = output_mask[i] & ~empty & ~done_q[i] & ~rst;
      data_o[i]  = output_mask[i] ? head : {`BODY, {(`DW-2){1'b0}}};
      acc[i]     = valid_o[i] & ready_i[i];
    end
  end

  // The head retires once every masked branch has taken it, now or earlier.
  assign wr_en = in_valid & ~full & ~rst;
  assign pop   = ~empty & ~rst & (&(~output_mask | done_q | acc));

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    done_d   = pop ? 5'b0 : (done_q | acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[depth_log-1:0]] <= in_data;
  end

`ifdef SPLIT_ROUTER_PERF_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fwd_cnt_d   = pop ? fwd_cnt_q + 32'd1 : fwd_cnt_q;
    stall_cnt_d = (~empty & ~pop) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fwd_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  logic stalled_q;

  always_ff @(posedge clk) begin
    if (rst) stalled_q <= 1'b0;
    else     stalled_q <= in_valid & full;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (output_mask != 5'b0) else $error("split_router: output_mask is zero");
      assert ($onehot(input_sel)) else $error("split_router: input_sel is not one-hot");
      assert ((input_sel & output_mask) == 5'b0) else $error("split_router: input_sel overlaps output_mask");
      assert (!stalled_q || in_valid) else $error("split_router: upstream dropped valid before the flit was accepted");
    end
  end
`endif

endmodule

// File: tb/tb_split_router.sv
// Directed bench for split_router: local source forked to west/east/north through a 4-entry FIFO.
`ifndef DW
`define DW 34
`endif
`ifndef BODY
`define BODY 2'b10
`endif

module tb_split_router;

  logic            clk;
  logic            rst;
  logic [`DW-1:0]  data_i  [5];
  logic            valid_i [5];
  logic            ready_o [5];
  logic [`DW-1:0]  data_o  [5];
  logic            valid_o [5];
  logic            ready_i [5];
  logic [31:0]     fwd_cnt_o;
  logic [31:0]     stall_cnt_o;

  logic [4:0]      vo;
  logic [4:0]      ro;
  int              checks;
  int              errors;

  localparam logic [`DW-1:0] BODY_WORD = {`BODY, {(`DW-2){1'b0}}};

  split_router #(
    .input_sel  (5'b00001),
    .output_mask(5'b01110),
    .depth_log  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .fwd_cnt_o  (fwd_cnt_o),
    .stall_cnt_o(stall_cnt_o)
  );

  assign vo = {valid_o[4], valid_o[3], valid_o[2], valid_o[1], valid_o[0]};
  assign ro = {ready_o[4], ready_o[3], ready_o[2], ready_o[1], ready_o[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [63:0] exp);
    for (int i = 1; i <= 3; i++) check(tag, 64'(data_o[i]), exp);
  endtask

  function automatic logic [31:0] perf(input logic [31:0] n);
`ifdef SPLIT_ROUTER_PERF_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [4:0] r);
    for (int i = 0; i < 5; i++) ready_i[i] = r[i];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i[i]  = '0;
      valid_i[i] = 1'b0;
      ready_i[i] = 1'b0;
    end
    cyc();
    cyc();
    #1;
    check("rst_ready", 64'(ro), 64'h0);
    check("rst_valid", 64'(vo), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(ro), 64'h01);
    check("post_rst_valid", 64'(vo), 64'h0);
    check("post_rst_fwd", 64'(fwd_cnt_o), 64'h0);
    check("post_rst_stall", 64'(stall_cnt_o), 64'h0);
    check("unmasked_data", 64'(data_o[0]), 64'(BODY_WORD));

    // Broadcast with every branch ready: one flit per cycle, first visible a cycle after its write.
    set_ready(5'b11111);
    for (int k = 1; k <= 9; k++) begin
      valid_i[0] = (k <= 8);
      data_i[0]  = `DW'(k);
      #1;
      if (k == 1) check("bc_first_empty", 64'(vo), 64'h0);
      else begin
        check("bc_valid", 64'(vo), 64'h0E);
        chk3("bc_data", 64'(k - 1));
      end
      cyc();
    end
    #1;
    check("bc_drained", 64'(vo), 64'h0);
    check("bc_fwd", 64'(fwd_cnt_o), 64'(perf(32'd8)));
    check("bc_stall", 64'(stall_cnt_o), 64'(perf(32'd0)));

    // Skewed branches: east holds off for three cycles.
    set_ready(5'b11011);
    valid_i[0] = 1'b1; data_i[0] = `DW'('hA1);
    cyc();
    data_i[0] = `DW'('hB2);
    #1;
    check("skew_a_all", 64'(vo), 64'h0E);
    chk3("skew_a_data", 64'hA1);
    cyc();
    valid_i[0] = 1'b0;
    #1;
    check("skew_east_only1", 64'(vo), 64'h04);
    check("skew_east_data1", 64'(data_o[2]), 64'hA1);
    cyc();
    #1;
    check("skew_east_only2", 64'(vo), 64'h04);
    cyc();
    set_ready(5'b11111);
    #1;
    check("skew_east_only3", 64'(vo), 64'h04);
    check("skew_east_data3", 64'(data_o[2]), 64'hA1);
    cyc();
    #1;
    check("skew_b_all", 64'(vo), 64'h0E);
    chk3("skew_b_data", 64'hB2);
    cyc();
    #1;
    check("skew_drained", 64'(vo), 64'h0);
    check("skew_fwd", 64'(fwd_cnt_o), 64'(perf(32'd10)));
    check("skew_stall", 64'(stall_cnt_o), 64'(perf(32'd3)));

    // Backpressure to full: four writes fill the FIFO, the rest wait on ready_o.
    set_ready(5'b00000);
    for (int k = 0; k < 4; k++) begin
      valid_i[0] = 1'b1; data_i[0] = `DW'('h31 + k);
      #1;
      check("bp_fill_ready", 64'(ro), 64'h01);
      cyc();
    end
    data_i[0] = `DW'('h35);
    #1;
    check("bp_full_ready", 64'(ro), 64'h00);
    check("bp_full_valid", 64'(vo), 64'h0E);
    chk3("bp_full_head", 64'h31);
    cyc();
    set_ready(5'b11111);
    #1;
    check("bp_nobypass_ready", 64'(ro), 64'h00);
    chk3("bp_drain0", 64'h31);
    cyc();
    #1;
    check("bp_reopen_ready", 64'(ro), 64'h01);
    chk3("bp_drain1", 64'h32);
    cyc();
    data_i[0] = `DW'('h36);
    #1;
    check("bp_ready2", 64'(ro), 64'h01);
    chk3("bp_drain2", 64'h33);
    cyc();
    valid_i[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_tail_valid", 64'(vo), 64'h0E);
      chk3("bp_tail_data", 64'h34 + 64'(k));
      cyc();
    end
    #1;
    check("bp_drained", 64'(vo), 64'h0);
    check("bp_fwd", 64'(fwd_cnt_o), 64'(perf(32'd16)));
    check("bp_stall", 64'(stall_cnt_o), 64'(perf(32'd7)));

    // Port isolation: traffic on non-selected ports must never be forwarded.
    for (int i = 1; i < 5; i++) begin
      valid_i[i] = 1'b1; data_i[i] = `DW'('hDEAD);
    end
    valid_i[0] = 1'b1; data_i[0] = `DW'('h77);
    #1;
    check("iso_ready", 64'(ro), 64'h01);
    check("iso_valid_empty", 64'(vo), 64'h0);
    cyc();
    valid_i[0] = 1'b0;
    #1;
    check("iso_ready2", 64'(ro), 64'h01);
    check("iso_valid", 64'(vo), 64'h0E);
    chk3("iso_data", 64'h77);
    cyc();
    #1;
    check("iso_drained", 64'(vo), 64'h0);
    cyc();
    #1;
    check("iso_still_empty", 64'(vo), 64'h0);
    for (int i = 1; i < 5; i++) valid_i[i] = 1'b0;
    check("iso_fwd", 64'(fwd_cnt_o), 64'(perf(32'd17)));

    // Reset mid-flit: west has the head, east and north do not.
    set_ready(5'b00000);
    for (int k = 0; k < 3; k++) begin
      valid_i[0] = 1'b1; data_i[0] = `DW'('h61 + k);
      cyc();
    end
    valid_i[0] = 1'b0;
    set_ready(5'b00010);
    #1;
    check("mid_head_valid", 64'(vo), 64'h0E);
    chk3("mid_head_data", 64'h61);
    cyc();
    set_ready(5'b00000);
    #1;
    check("mid_west_done", 64'(vo), 64'h0C);
    check("mid_stall", 64'(stall_cnt_o), 64'(perf(32'd10)));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(vo), 64'h0);
    check("mid_rst_ready", 64'(ro), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("mid_after_valid", 64'(vo), 64'h0);
    check("mid_after_ready", 64'(ro), 64'h01);
    check("mid_after_fwd", 64'(fwd_cnt_o), 64'h0);
    check("mid_after_stall", 64'(stall_cnt_o), 64'h0);
    set_ready(5'b11111);
    valid_i[0] = 1'b1; data_i[0] = `DW'('h55);
    cyc();
    valid_i[0] = 1'b0;
    #1;
    check("mid_new_valid", 64'(vo), 64'h0E);
    chk3("mid_new_data", 64'h55);
    cyc();
    #1;
    check("mid_new_once", 64'(vo), 64'h0);
    check("mid_new_fwd", 64'(fwd_cnt_o), 64'(perf(32'd1)));
    check("mid_new_stall", 64'(stall_cnt_o), 64'(perf(32'd0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/split_router.md
Name: split_router

Overview:
- Buffered one-to-many fork (multicast) router; the counterpart of the merge router in the NoC.
- Accepts flits on one statically selected input port and replicates each flit, unmodified, to every port in a static output mask.
- Buffers incoming flits in one FWFT FIFO and uses eager-fork handshaking, so each output branch may accept the flit in a different cycle.
- Instantiated at multicast/tree-split points of the mesh with the same 5-port (local/west/east/north/south) interface as the other routers.

Parameters:
- input_sel, [0:4], default 5'b10000: one-hot source port; [0]-local [1]-west [2]-east [3]-north [4]-south.
- output_mask, [0:4], default 5'b01000: destination ports, 1 means replicate to that port. Must be nonzero and must not overlap input_sel.
- depth_log, default `SPLIT_ROUTER_BUFFER_DEPTH_LOG: FIFO depth is 2**depth_log entries, minimum 1 (2 entries).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- data_i[5]  input  `DW  per-port input flit
- valid_i[5]  input  1  per-port input valid
- ready_o[5]  output  1  per-port input ready
- data_o[5]  output  `DW  per-port output flit
- valid_o[5]  output  1  per-port output valid
- ready_i[5]  input  1  per-port downstream ready
- fwd_cnt_o  output  32  flits fully forwarded (see Optional Feature)
- stall_cnt_o  output  32  head-blocked cycles (see Optional Feature)

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: FIFO emptied, all done[] bits cleared, counters cleared.
  - While rst is high: all ready_o=0 and all valid_o=0, forced combinationally.
  - After rst falls: ready_o[input_sel]=1 in the first cycle.
- Input side:
  - ready_o[s] = ~full for s = input_sel; all other ready_o=0.
  - Write occurs when valid_i[s] & ready_o[s]. Non-selected inputs are ignored.
  - No bypass: when full, writes are refused even if a pop happens in the same cycle. A flit written at edge t is visible on the outputs in cycle t+1.
- Output side: state is a per-port register done[i].
  - Head flit: valid_o[i] = output_mask[i] & ~empty & ~done[i] & ~rst.
  - data_o[i] = FIFO head if output_mask[i], else {`BODY, zeros}.
  - All bits, including the flit-type field, pass through unchanged.
- Branch accept: acc[i] = valid_o[i] & ready_i[i].
- Pop condition: for every masked i, done[i] | acc[i].
  - On pop: FIFO read, all done[] cleared.
  - Otherwise: done[i] is set for each acc[i]. done[i] stays set until pop.
- Each masked output sees each flit exactly once, in FIFO order. One flit can pop per cycle (full throughput when all branches are ready).
- Simultaneous read and write when neither empty nor full: both occur and the occupancy is unchanged.
- Empty: no valid_o asserted and done[] stays 0.
- Unmasked outputs: valid_o=0; their ready_i are ignored.
- Reset mid-flit: partially forwarded head flit is discarded and done[] cleared; no output re-sends it.
- Simulation assertions (non-synth), each an error:
  - output_mask==0;
  - input_sel not one-hot;
  - input_sel & output_mask != 0;
  - valid_i[s] dropped while ready_o[s]=0 with the flit unaccepted (upstream protocol violation).

Optional Feature:
- Macro: SPLIT_ROUTER_PERF_EN.
- Defined:
  - fwd_cnt_o increments on every pop.
  - stall_cnt_o increments each cycle the FIFO is non-empty and no pop occurs.
  - Both are 32-bit, wrap modulo 2^32, and clear on rst.
- Undefined: both ports tied to 0 and no counter logic is synthesized. Fork behaviour is identical either way.

Test Plan:
- Broadcast, all ready: input_sel=local, output_mask=west|east|north; send flits 0x1..0x8 back-to-back with all ready_i=1. Each masked output receives 0x1..0x8 in order, one per cycle, first at cycle t+1. With PERF_EN: fwd_cnt_o=8, stall_cnt_o=0.
- Skewed branches: hold ready_i[east]=0 for 3 cycles while west/north are ready. West/north see flit A once then no valid. Flit A pops in the cycle east accepts it. Next flit appears on all three the following cycle. With PERF_EN: stall_cnt_o=3.
- Backpressure to full: depth_log=2, all ready_i=0, push 6 flits. ready_o[local] drops after 4 writes. Release ready_i; all 4 flits drain on each output, and the 2 remaining flits are accepted afterwards with no loss or duplication.
- Port isolation: drive valid_i on non-selected ports with flits 0xDEAD. Those flits never appear on any output, ready_o stays 0 on those ports, and unmasked valid_o stays 0.
- Reset mid-operation: 3 flits queued, west has taken the head and east has not; assert rst for 1 cycle. All valid_o=0 and ready_o=0 during reset. The FIFO is empty afterwards; a new flit 0x55 is delivered once to both west and east.
